// File: rtl/delay_measure.sv
// Multi-lane round-trip delay meter: launches all lanes, counts edges until each return is seen.
// Define DELAY_MEASURE_SYNC_EN to put a two-flop synchronizer on every ret bit (+2 on each count).
module delay_measure #(
  parameter int N   = 1,
  parameter int W   = 8,
  parameter int TMO = 200
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [N-1:0]   launch,
  input  logic [N-1:0]   ret,
  output logic           busy,
  output logic           done,
  output logic [N*W-1:0] cnt,
  output logic [N-1:0]   tmo
);

  typedef enum logic [1:0] {IDLE, MEAS, RECOVER, DONE} state_t;

  localparam logic [W-1:0] TMOW = W'(TMO);

  state_t         state, state_n;
  logic [W-1:0]   cyc, cyc_n, cyc_inc;
  logic [N-1:0]   seen, seen_n, launch_n, tmo_n, ret_s;
  logic [N*W-1:0] cnt_n;
  logic           busy_n, done_n;

`ifdef DELAY_MEASURE_SYNC_EN
  logic [N-1:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ret;
      sync2 <= sync1;
    end
  end

  assign ret_s = sync2;
`else
  assign ret_s = ret;
`endif

  assign cyc_inc = cyc + 1'b1;

  always_comb begin
    state_n  = state;
    cyc_n    = cyc;
    seen_n   = seen;
    launch_n = launch;
    cnt_n    = cnt;
    tmo_n    = tmo;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          launch_n = '1;
          cyc_n    = '0;
          cnt_n    = '0;
          tmo_n    = '0;
          seen_n   = '0;
          state_n  = MEAS;
        end
      end
      MEAS: begin
        cyc_n = cyc_inc;
        for (int unsigned k = 0; k < N; k++) begin
          if (ret_s[k] && !seen[k]) begin
            cnt_n[k*W +: W] = cyc_inc;
            seen_n[k]       = 1'b1;
          end
        end
        // lanes caught on the timeout edge itself still keep their real count
        if (&seen_n) begin
          state_n = RECOVER;
        end else if (cyc_inc == TMOW) begin
          for (int unsigned k = 0; k < N; k++) begin
            if (!seen_n[k]) begin
              cnt_n[k*W +: W] = '1;
              tmo_n[k]        = 1'b1;
            end
          end
          state_n = RECOVER;
        end
        if (state_n == RECOVER) begin
          launch_n = '0;
          cyc_n    = '0;
        end
      end
      RECOVER: begin
        cyc_n = cyc_inc;
        if (ret_s == '0 || cyc_inc == TMOW) begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy_n = (state_n != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cyc    <= '0;
      seen   <= '0;
      launch <= '0;
      cnt    <= '0;
      tmo    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cyc    <= cyc_n;
      seen   <= seen_n;
      launch <= launch_n;
      cnt    <= cnt_n;
      tmo    <= tmo_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_delay_measure.sv
// Scoreboard bench for delay_measure: a 4-lane instance (TMO=20) and a 1-lane instance (TMO=10)
// driven by modelled delay lanes; expectations follow the sync-enable macro setting.
module tb_delay_measure;

  localparam int W  = 8;
  localparam int TA = 20;
  localparam int TB = 10;
`ifdef DELAY_MEASURE_SYNC_EN
  localparam int OFS = 3;
`else
  localparam int OFS = 1;
`endif

  typedef struct {
    logic [31:0] cnt;
    logic [3:0]  tmo;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sa  = 1'b0;
  logic        sb  = 1'b0;
  logic [3:0]  la, ra, tmoa;
  logic [31:0] cnta;
  logic        busya, donea;
  logic [0:0]  lb, rb, tmob;
  logic [7:0]  cntb;
  logic        busyb, doneb;

  int          da [4];
  logic [3:0]  ena = '0;
  logic [3:0]  hia = '0;
  logic        enb = 1'b0;
  logic        hib = 1'b0;
  logic [15:0] sr [4];

  logic        cur = 1'b0;
  logic [31:0] vcnt;
  logic [3:0]  vtmo, vlaunch;
  logic        vdone, vbusy;

  always #5 clk = ~clk;

  delay_measure #(.N(4), .W(W), .TMO(TA)) u_a (
    .clk(clk), .rst(rst), .start(sa), .launch(la), .ret(ra),
    .busy(busya), .done(donea), .cnt(cnta), .tmo(tmoa)
  );

  delay_measure #(.N(1), .W(W), .TMO(TB)) u_b (
    .clk(clk), .rst(rst), .start(sb), .launch(lb), .ret(rb),
    .busy(busyb), .done(doneb), .cnt(cntb), .tmo(tmob)
  );

  // lane k returns launch[k] delayed by da[k] whole cycles
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) sr[k] <= {sr[k][14:0], la[k]};
  end

  always_comb begin
    ra = '0;
    for (int k = 0; k < 4; k++)
      ra[k] = hia[k] | (ena[k] & ((da[k] == 0) ? la[k] : sr[k][da[k]-1]));
    rb[0] = hib | (enb & lb[0]);
  end

  always_comb begin
    vcnt    = cur ? {24'b0, cntb} : cnta;
    vtmo    = cur ? {3'b0, tmob} : tmoa;
    vlaunch = cur ? {3'b0, lb} : la;
    vdone   = cur ? doneb : donea;
    vbusy   = cur ? busyb : busya;
  end

  task automatic go(input bit sel, input bit poke, input string tag);
    exp_t e;
    int c, mx, maxd, m, r, n, nl, t, d;
    bit anyhi, anyen, en, hi;
    logic [3:0] lmask;
    cur = sel;
    nl = sel ? 1 : 4;
    t  = sel ? TB : TA;
    lmask = sel ? 4'h1 : 4'hf;
    e.cnt = '0; e.tmo = '0;
    mx = 0; maxd = 0; anyhi = 0; anyen = 0;
    for (int k = 0; k < nl; k++) begin
      en = sel ? enb : ena[k];
      hi = sel ? hib : hia[k];
      d  = sel ? 0 : da[k];
      if (hi) c = 1;
      else if (en) c = d + OFS;
      else c = t + 1;
      if (c > t) begin
        e.cnt[k*W +: W] = '1;
        e.tmo[k] = 1'b1;
      end else begin
        e.cnt[k*W +: W] = W'(c);
      end
      if (c > mx) mx = c;
      if (hi) anyhi = 1;
      else if (en) begin
        anyen = 1;
        if (d > maxd) maxd = d;
      end
    end
    m = (mx > t) ? t : mx;
    r = anyhi ? t : (anyen ? maxd + OFS : 1);
    e.lat = m + r;
    q.push_back(e);

    repeat (4) @(negedge clk);
    if (sel) sb = 1'b1; else sa = 1'b1;
    @(negedge clk);
    sa = 1'b0; sb = 1'b0;
    vectors++;
    if (vbusy !== 1'b1 || vlaunch !== lmask) begin
      miscompares++;
      $display("FAIL %s launch: busy=%b launch=%h, want busy=1 launch=%h", tag, vbusy, vlaunch, lmask);
    end
    n = 0;
    while (!vdone && n < 300) begin
      @(negedge clk);
      n++;
      if (poke && n == 3) begin
        if (sel) sb = 1'b1; else sa = 1'b1;
      end else begin
        sa = 1'b0; sb = 1'b0;
      end
    end
    sa = 1'b0; sb = 1'b0;
    e = q.pop_front();
    vectors++;
    if (vdone !== 1'b1 || n != e.lat) begin
      miscompares++;
      $display("FAIL %s latency: done after %0d edges (done=%b), want %0d", tag, n, vdone, e.lat);
    end
    vectors++;
    if (vcnt !== e.cnt) begin
      miscompares++;
      $display("FAIL %s cnt: got %h, want %h", tag, vcnt, e.cnt);
    end
    vectors++;
    if (vtmo !== e.tmo) begin
      miscompares++;
      $display("FAIL %s tmo: got %b, want %b", tag, vtmo, e.tmo);
    end
    @(negedge clk);
    vectors++;
    if (vdone !== 1'b0 || vbusy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_pulse: done=%b busy=%b, want 0 0", tag, vdone, vbusy);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (vcnt !== e.cnt || vtmo !== e.tmo || vbusy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s hold: cnt=%h tmo=%b busy=%b, want cnt=%h tmo=%b busy=0", tag, vcnt, vtmo, vbusy, e.cnt, e.tmo);
    end
  endtask

  task automatic test_reset();
    repeat (20) @(negedge clk);
    vectors++;
    if (la !== '0 || busya !== 1'b0 || donea !== 1'b0 || cnta !== '0 || tmoa !== '0) begin
      miscompares++;
      $display("FAIL reset_a: launch=%h busy=%b done=%b cnt=%h tmo=%b, want all 0", la, busya, donea, cnta, tmoa);
    end
    vectors++;
    if (lb !== '0 || busyb !== 1'b0 || doneb !== 1'b0 || cntb !== '0 || tmob !== '0) begin
      miscompares++;
      $display("FAIL reset_b: launch=%b busy=%b done=%b cnt=%h tmo=%b, want all 0", lb, busyb, doneb, cntb, tmob);
    end
    rst = 1'b0;
  endtask

  task automatic test_tied();
    enb = 1'b1; hib = 1'b0;
    go(1'b1, 1'b0, "tied");
  endtask

  task automatic test_lanes();
    da[0] = 0; da[1] = 3; da[2] = 7; da[3] = 12;
    ena = 4'hf; hia = 4'h0;
    go(1'b0, 1'b0, "lanes");
  endtask

  task automatic test_timeout();
    da[0] = 0; da[1] = 0; da[2] = 2; da[3] = 5;
    ena = 4'b1101; hia = 4'h0;
    go(1'b0, 1'b0, "timeout_a");
    enb = 1'b0;
    go(1'b1, 1'b0, "timeout_b");
  endtask

  task automatic test_stuck();
    hib = 1'b1;
    go(1'b1, 1'b0, "stuck_b");
    hib = 1'b0; enb = 1'b1;
  endtask

  task automatic test_back_to_back();
    da[0] = 0; da[1] = 3; da[2] = 7; da[3] = 12;
    ena = 4'hf; hia = 4'h0;
    go(1'b0, 1'b1, "busy_start");
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) da[k] = $urandom_range(0, 16);
      ena = 4'($urandom);
      go(1'b0, 1'b0, "random");
    end
  endtask

  task automatic test_rst_mid();
    int n;
    bit seen_done;
    cur = 1'b0;
    for (int k = 0; k < 4; k++) da[k] = 12;
    ena = 4'hf; hia = 4'h0;
    repeat (4) @(negedge clk);
    sa = 1'b1;
    @(negedge clk);
    sa = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (busya !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_busy: busy=%b, want 1", busya);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (la !== '0 || busya !== 1'b0 || donea !== 1'b0 || cnta !== '0 || tmoa !== '0) begin
      miscompares++;
      $display("FAIL rst_mid: launch=%h busy=%b done=%b cnt=%h tmo=%b, want all 0", la, busya, donea, cnta, tmoa);
    end
    rst = 1'b0;
    seen_done = 0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (donea || busya) seen_done = 1;
    end
    vectors++;
    if (seen_done) begin
      miscompares++;
      $display("FAIL rst_mid_quiet: done/busy seen after abort, want none");
    end
  endtask

  initial begin
    test_reset();
    test_tied();
    test_lanes();
    test_timeout();
    test_stuck();
    test_back_to_back();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/delay_measure.md
DELAY_MEASURE -- requirements
Module: delay_measure

Interface
REQ-001 SHALL have parameter N, default 1: number of lanes measured in parallel.
REQ-002 SHALL have parameter W, default 8: width of each per-lane cycle count.
REQ-003 SHALL have parameter TMO, default 200: maximum cycles per phase; legal range 4 to 2^W-2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: request to run one measurement.
REQ-007 SHALL have port launch, output, N bits: stimulus to the delay lanes under test.
REQ-008 SHALL have port ret, input, N bits: asynchronous returns from the lanes under test.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a measurement.
REQ-011 SHALL have port cnt, output, N*W bits: lane k count in bits [k*W+W-1:k*W].
REQ-012 SHALL have port tmo, output, N bits: lane k was not seen before timeout.

Function
REQ-013 SHALL implement states IDLE, MEAS, RECOVER and DONE, all registered; launch, busy, done, cnt and tmo SHALL be register outputs.
REQ-014 SHALL, in IDLE with start=1 at an edge, set launch to all ones, clear cyc, cnt and tmo to 0, and enter MEAS; start SHALL be ignored in every other state.
REQ-015 SHALL, at each MEAS edge, increment the internal counter cyc (W bits) and record cnt[k]=cyc+1 for each lane whose sampled ret_s[k] is 1 and which is not already marked seen, then mark that lane seen.
REQ-016 SHALL define cnt[k] as the number of edges from the launch-asserting edge to the first edge that samples ret_s[k] high; a lane already high on the first MEAS edge SHALL record 1 (sync off) or 3 (sync on, ret tied to launch).
REQ-017 SHALL leave MEAS for RECOVER on the edge where all lanes are seen, including lanes seen on that same edge.
REQ-018 SHALL, when cyc+1 equals TMO with lanes unseen, set each unseen lane's cnt to all ones and its tmo bit to 1, then enter RECOVER.
REQ-019 SHALL, on entry to RECOVER, drive launch to 0, clear cyc, and wait until all ret_s are 0 or TMO cycles elapse, then enter DONE.
REQ-020 SHALL hold done at 1 for exactly the single DONE cycle, then return to IDLE.
REQ-021 SHALL keep cnt and tmo stable from DONE until the next accepted start.
REQ-022 SHALL never let cyc wrap; TMO bounds it below 2^W-1.

Reset
REQ-023 SHALL, at an edge with rst=1 in any state, enter IDLE with launch=0, busy=0, done=0, cnt=0, tmo=0, cyc=0, all seen flags cleared and synchronizer stages cleared.
REQ-024 SHALL give reset priority over start and over every other event on the same edge.
REQ-025 SHALL abort a measurement in progress on reset without producing a done pulse.

Configuration
REQ-026 SHALL use macro DELAY_MEASURE_SYNC_EN to select the ret sampling path.
REQ-027 SHALL, with DELAY_MEASURE_SYNC_EN defined, pass each ret bit through a two-flop synchronizer to form ret_s, adding 2 cycles to every count.
REQ-028 SHALL, without DELAY_MEASURE_SYNC_EN, form ret_s from ret sampled directly, with no synchronizer flops.

Verification
REQ-029 SHALL cover: N=1, sync off, ret tied to launch, pulse start -> cnt=1, tmo=0, and done one cycle after RECOVER sees ret low.
REQ-030 SHALL cover: N=4, sync on, lanes delayed 0, 3, 7 and 12 cycles -> cnt=3, 6, 10, 15 and tmo=0000.
REQ-031 SHALL cover: N=2, TMO=20, lane 1 ret held 0 -> cnt lane1=2^W-1, tmo=10, and done after 20 MEAS cycles.
REQ-032 SHALL cover: ret stuck high in RECOVER, TMO=10 -> DONE reached after 10 RECOVER cycles.
REQ-033 SHALL cover: start pulsed while busy -> ignored and cnt unchanged; rst asserted mid-MEAS -> next cycle launch=0 and busy=0, with no done pulse.
